imem_uart_loader: RTL and testbench



---
 rtl/imem_uart_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_imem_uart_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_uart_loader.sv
// Receives a checksummed program image over an 8N1 UART, writes it word by word
// into the instruction RAM, and holds the CPU in reset until the image verifies.
module imem_uart_loader #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          MEM_WORDS    = 256,
  parameter int          TIMEOUT_CLKS = 20 * CLKS_PER_BIT * 10,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam int WW = $clog2(MEM_WORDS + 1);
  localparam int AW = $clog2(MEM_WORDS) + 3;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {WAIT_SYNC, GET_COUNT, GET_DATA, WRITE_WORD, GET_CHK} state_t;

  logic rx_meta, rx_sync, rx_prev;

  rx_state_t rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic          byte_valid, byte_valid_n;
  logic          frame_err, frame_err_n;

  state_t state, state_n;
  logic [AW-1:0] addr, addr_n;
  logic [31:0]   wdata, wdata_n;
  logic [7:0]    chk, chk_n;
  logic [WW-1:0] words_left, words_left_n;
  logic [1:0]    byte_idx, byte_idx_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          we_n, done_n, hold_n, err_n;
  logic          timeout, abort;

  // rx_prev lets the idle receiver react only to a genuine high-to-low transition
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_state   <= rx_state_n;
      rx_cnt     <= rx_cnt_n;
      rx_bit     <= rx_bit_n;
      rx_shift   <= rx_shift_n;
      byte_valid <= byte_valid_n;
      frame_err  <= frame_err_n;
    end
  end

  always_comb begin
    rx_state_n   = rx_state;
    rx_cnt_n     = rx_cnt + CW'(1);
    rx_bit_n     = rx_bit;
    rx_shift_n   = rx_shift;
    byte_valid_n = 1'b0;
    frame_err_n  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_sync) rx_state_n = RX_START;
      end
      RX_START: begin
        if (rx_cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_sync, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
          rx_state_n = RX_IDLE;
          if (rx_sync) byte_valid_n = 1'b1;
          else         frame_err_n  = 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_SYNC;
      addr       <= '0;
      wdata      <= '0;
      chk        <= '0;
      words_left <= '0;
      byte_idx   <= '0;
      tcnt       <= '0;
      imem_we    <= 1'b0;
      load_done  <= 1'b0;
      cpu_hold   <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state      <= state_n;
      addr       <= addr_n;
      wdata      <= wdata_n;
      chk        <= chk_n;
      words_left <= words_left_n;
      byte_idx   <= byte_idx_n;
      tcnt       <= tcnt_n;
      imem_we    <= we_n;
      load_done  <= done_n;
      cpu_hold   <= hold_n;
      load_err   <= err_n;
    end
  end

  // A timeout takes priority over a byte landing in the same cycle
  assign timeout = (state != WAIT_SYNC) && (tcnt == TW'(TIMEOUT_CLKS - 1));
  assign abort   = timeout || (frame_err && (state != WAIT_SYNC));

  always_comb begin
    state_n      = state;
    addr_n       = addr;
    wdata_n      = wdata;
    chk_n        = chk;
    words_left_n = words_left;
    byte_idx_n   = byte_idx;
    tcnt_n       = (state == WAIT_SYNC || byte_valid) ? '0 : tcnt + TW'(1);
    we_n         = 1'b0;
    done_n       = 1'b0;
    hold_n       = cpu_hold;
    err_n        = load_err;
    if (abort) begin
      err_n   = 1'b1;
      state_n = WAIT_SYNC;
    end else begin
      case (state)
        WAIT_SYNC: begin
          if (byte_valid && rx_shift == SYNC_BYTE) begin
            hold_n     = 1'b1;
            err_n      = 1'b0;
            addr_n     = '0;
            chk_n      = '0;
            byte_idx_n = '0;
            state_n    = GET_COUNT;
          end
        end
        GET_COUNT: begin
          if (byte_valid) begin
            if ({24'd0, rx_shift} > 32'(MEM_WORDS)) begin
              err_n   = 1'b1;
              state_n = WAIT_SYNC;
            end else begin
              words_left_n = (rx_shift == 8'd0) ? WW'(MEM_WORDS) : WW'(rx_shift);
              byte_idx_n   = '0;
              state_n      = GET_DATA;
            end
          end
        end
        GET_DATA: begin
          if (byte_valid) begin
            wdata_n    = {wdata[23:0], rx_shift};
            chk_n      = chk ^ rx_shift;
            byte_idx_n = byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              we_n    = 1'b1;
              state_n = WRITE_WORD;
            end
          end
        end
        // imem_we is high during this state; advance once the write has been presented
        WRITE_WORD: begin
          addr_n       = addr + AW'(4);
          words_left_n = words_left - WW'(1);
          state_n      = (words_left == WW'(1)) ? GET_CHK : GET_DATA;
        end
        GET_CHK: begin
          if (byte_valid) begin
            state_n = WAIT_SYNC;
            if (rx_shift == chk) begin
              done_n = 1'b1;
              hold_n = 1'b0;
            end else begin
              err_n = 1'b1;
            end
          end
        end
        default: state_n = WAIT_SYNC;
      endcase
    end
  end

  assign imem_addr  = 32'(addr);
  assign imem_wdata = wdata;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: drives 8N1 frames onto uart_rx and checks
// RAM writes, load_done/cpu_hold/load_err behaviour against hand-derived values.
module tb_imem_uart_loader;

  localparam int CPB = 4;
  localparam int MW  = 256;
  localparam int TO  = 20 * CPB * 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        uart_rx = 1'b1;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  imem_uart_loader #(
    .CLKS_PER_BIT(CPB),
    .MEM_WORDS   (MW),
    .TIMEOUT_CLKS(TO),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .uart_rx   (uart_rx),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          done_total = 0;
  logic        hold_at_done = 1'b1;

  // Log every write strobe and load_done pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (imem_we) begin
        wr_addr.push_back(imem_addr);
        wr_data.push_back(imem_wdata);
      end
      if (load_done) begin
        done_total   <= done_total + 1;
        hold_at_done <= cpu_hold;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task applyStimulus(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] xor_of(input logic [7:0] data[$]);
    logic [7:0] x = 8'h00;
    foreach (data[i]) x ^= data[i];
    return x;
  endfunction

  function automatic logic [31:0] get_addr(input int i);
    return (i < wr_addr.size()) ? wr_addr[i] : 32'hDEAD_DEAD;
  endfunction

  function automatic logic [31:0] get_data(input int i);
    return (i < wr_data.size()) ? wr_data[i] : 32'hDEAD_DEAD;
  endfunction

  task send_body(input logic [7:0] count, input logic [7:0] data[$], input logic [7:0] chk);
    applyStimulus(count, 1'b1);
    foreach (data[i]) applyStimulus(data[i], 1'b1);
    applyStimulus(chk, 1'b1);
  endtask

  task send_frame(input logic [7:0] count, input logic [7:0] data[$], input logic [7:0] chk);
    applyStimulus(8'hA5, 1'b1);
    send_body(count, data, chk);
  endtask

  logic [7:0] img1[$];
  logic [7:0] img3[$];
  logic [7:0] img4[$];
  logic [7:0] img5[$];
  logic [7:0] img6[$];
  int         wbase;
  int         dbase;
  int         seq_err;

  initial begin
    img1 = '{8'h08, 8'h00, 8'h00, 8'h87, 8'h3C, 8'h08, 8'h40, 8'h00};
    img3 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    img5 = '{8'h01, 8'h02, 8'h03, 8'h04};
    img6 = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
    for (int i = 0; i < 4 * MW; i++) img4.push_back(8'h00);

    repeat (3) @(negedge clk);
    checkOutput("reset_we",    {31'd0, imem_we},   32'd0);
    checkOutput("reset_addr",  imem_addr,          32'd0);
    checkOutput("reset_wdata", imem_wdata,         32'd0);
    checkOutput("reset_hold",  {31'd0, cpu_hold},  32'd0);
    checkOutput("reset_done",  {31'd0, load_done}, 32'd0);
    checkOutput("reset_err",   {31'd0, load_err},  32'd0);
    reset = 1'b0;
    idle(5);

    // Two-word image; expected checksum is the XOR of all eight data bytes (0xFB)
    wbase = wr_addr.size(); dbase = done_total;
    applyStimulus(8'hA5, 1'b1);
    idle(4);
    checkOutput("t1_hold_on_sync", {31'd0, cpu_hold}, 32'd1);
    send_body(8'h02, img1, xor_of(img1));
    idle(10);
    checkOutput("t1_write_count", 32'(wr_addr.size() - wbase), 32'd2);
    checkOutput("t1_addr0", get_addr(wbase),     32'h0000_0000);
    checkOutput("t1_data0", get_data(wbase),     32'h0800_0087);
    checkOutput("t1_addr1", get_addr(wbase + 1), 32'h0000_0004);
    checkOutput("t1_data1", get_data(wbase + 1), 32'h3C08_4000);
    checkOutput("t1_done_count", 32'(done_total - dbase), 32'd1);
    checkOutput("t1_hold_at_done", {31'd0, hold_at_done}, 32'd0);
    checkOutput("t1_hold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("t1_err",  {31'd0, load_err}, 32'd0);

    // Bad checksum, then the same image resent correctly
    wbase = wr_addr.size(); dbase = done_total;
    send_frame(8'h02, img1, 8'h00);
    idle(10);
    checkOutput("t2_write_count", 32'(wr_addr.size() - wbase), 32'd2);
    checkOutput("t2_err",  {31'd0, load_err}, 32'd1);
    checkOutput("t2_hold", {31'd0, cpu_hold}, 32'd1);
    checkOutput("t2_no_done", 32'(done_total - dbase), 32'd0);
    applyStimulus(8'hA5, 1'b1);
    idle(4);
    checkOutput("t2_err_cleared", {31'd0, load_err}, 32'd0);
    send_body(8'h02, img1, xor_of(img1));
    idle(10);
    checkOutput("t2_done_count", 32'(done_total - dbase), 32'd1);
    checkOutput("t2_hold_released", {31'd0, cpu_hold}, 32'd0);

    // Junk bytes ahead of a one-word frame
    wbase = wr_addr.size(); dbase = done_total;
    applyStimulus(8'h55, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    idle(10);
    checkOutput("t3_junk_no_write", 32'(wr_addr.size() - wbase), 32'd0);
    send_frame(8'h01, img3, xor_of(img3));
    idle(10);
    checkOutput("t3_write_count", 32'(wr_addr.size() - wbase), 32'd1);
    checkOutput("t3_addr", get_addr(wbase), 32'h0000_0000);
    checkOutput("t3_data", get_data(wbase), 32'hDEAD_BEEF);
    checkOutput("t3_done_count", 32'(done_total - dbase), 32'd1);

    // COUNT=0 means the full memory depth
    wbase = wr_addr.size(); dbase = done_total;
    send_frame(8'h00, img4, 8'h00);
    idle(10);
    checkOutput("t4_write_count", 32'(wr_addr.size() - wbase), 32'(MW));
    checkOutput("t4_first_addr", get_addr(wbase), 32'h0000_0000);
    checkOutput("t4_last_addr",  get_addr(wbase + MW - 1), 32'h0000_03FC);
    seq_err = 0;
    for (int i = 0; i < MW; i++)
      if (get_addr(wbase + i) !== 32'(4 * i) || get_data(wbase + i) !== 32'd0) seq_err++;
    checkOutput("t4_sequence_errors", 32'(seq_err), 32'd0);
    checkOutput("t4_final_addr", imem_addr, 32'h0000_0400);
    checkOutput("t4_done_count", 32'(done_total - dbase), 32'd1);

    // Inter-byte timeout in GET_DATA
    wbase = wr_addr.size(); dbase = done_total;
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'h12, 1'b1);
    applyStimulus(8'h34, 1'b1);
    idle(TO / 2);
    checkOutput("t5_no_early_timeout", {31'd0, load_err}, 32'd0);
    idle(TO / 2 + 200);
    checkOutput("t5_timeout_no_write", 32'(wr_addr.size() - wbase), 32'd0);
    checkOutput("t5_timeout_err",  {31'd0, load_err}, 32'd1);
    checkOutput("t5_timeout_hold", {31'd0, cpu_hold}, 32'd1);
    checkOutput("t5_timeout_no_done", 32'(done_total - dbase), 32'd0);

    // Framing error during GET_DATA
    applyStimulus(8'hA5, 1'b1);
    idle(4);
    checkOutput("t5_frame_err_cleared", {31'd0, load_err}, 32'd0);
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'h12, 1'b1);
    applyStimulus(8'h34, 1'b0);
    idle(10);
    checkOutput("t5_frame_err", {31'd0, load_err}, 32'd1);
    checkOutput("t5_frame_hold", {31'd0, cpu_hold}, 32'd1);
    checkOutput("t5_frame_no_write", 32'(wr_addr.size() - wbase), 32'd0);

    // A short low glitch must not start a byte that would swallow the next frame
    uart_rx = 1'b0;
    idle(2);
    uart_rx = 1'b1;
    idle(10);
    send_frame(8'h01, img5, xor_of(img5));
    idle(10);
    checkOutput("t5_glitch_done", 32'(done_total - dbase), 32'd1);
    checkOutput("t5_glitch_writes", 32'(wr_addr.size() - wbase), 32'd1);
    checkOutput("t5_glitch_data", get_data(wbase), 32'h0102_0304);
    checkOutput("t5_glitch_err", {31'd0, load_err}, 32'd0);

    // Reset in the middle of a word
    wbase = wr_addr.size(); dbase = done_total;
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    idle(2);
    checkOutput("t6_hold_before_reset", {31'd0, cpu_hold}, 32'd1);
    reset = 1'b1;
    idle(1);
    checkOutput("t6_rst_we",    {31'd0, imem_we},   32'd0);
    checkOutput("t6_rst_addr",  imem_addr,          32'd0);
    checkOutput("t6_rst_wdata", imem_wdata,         32'd0);
    checkOutput("t6_rst_hold",  {31'd0, cpu_hold},  32'd0);
    checkOutput("t6_rst_done",  {31'd0, load_done}, 32'd0);
    checkOutput("t6_rst_err",   {31'd0, load_err},  32'd0);
    reset = 1'b0;
    idle(20);
    checkOutput("t6_no_partial_write", 32'(wr_addr.size() - wbase), 32'd0);
    send_frame(8'h01, img6, xor_of(img6));
    idle(10);
    checkOutput("t6_write_count", 32'(wr_addr.size() - wbase), 32'd1);
    checkOutput("t6_addr", get_addr(wbase), 32'h0000_0000);
    checkOutput("t6_data", get_data(wbase), 32'hCAFE_BABE);
    checkOutput("t6_done_count", 32'(done_total - dbase), 32'd1);
    checkOutput("t6_hold", {31'd0, cpu_hold}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
